// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
//   Pipelined integer adder/subtractor with a valid/ready handshake on both
//   sides. The WIDTH-bit carry chain is cut into STAGES equal chunks of
//   CW = WIDTH/STAGES bits. Each pipeline stage ripples one chunk, so a long
//   chain still closes timing at one result per cycle. WIDTH must be a
//   multiple of STAGES, and STAGES must be at least 1.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset; drops every in-flight beat
//   in_valid   in   operand beat valid
//   in_ready   out  a beat is accepted this cycle when in_valid is also high
//   in_a       in   operand A  [WIDTH]
//   in_b       in   operand B  [WIDTH]
//   in_sub     in   0: A+B+cin, 1: A+~B+1 (cin ignored)
//   in_cin     in   carry-in for add
//   out_valid  out  result valid
//   out_ready  in   consumer takes the result this cycle
//   out_sum    out  result modulo 2^WIDTH
//   out_carry  out  carry out of the MSB (for sub: 1 = no borrow)
//   out_ovf    out  signed overflow
//   out_zero   out  out_sum == 0
// -----------------------------------------------------------------------------
module pipe_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int CW = WIDTH / STAGES;

   // Subtraction is folded into the operands once, at issue time.
   logic [WIDTH-1:0]  b_eff;
   logic              cin_eff;
   logic [STAGES-1:0] vld_vec;
   logic [STAGES-1:0] adv;
   logic              zero_q;

   assign b_eff   = in_sub ? ~in_b : in_b;
   assign cin_eff = in_sub | in_cin;

   // Stage k may load when it is empty or everything downstream of it is
   // moving. Written as a running OR from the output end so that in_ready
   // depends only on out_ready and the stage valid bits, never on in_valid.
   always_comb begin : advance_chain
      logic take;
      take = out_ready;
      adv  = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         take   = take | ~vld_vec[k];
         adv[k] = take;
      end
   end

   assign in_ready = adv[0];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // Finished low bits held after this stage, and operand bits not yet added.
      localparam int DONE_W = (k + 1) * CW;
      localparam int PEND_W = WIDTH - DONE_W;

      logic              src_vld;
      logic              src_cin;
      logic              src_sa;
      logic              src_sb;
      logic [CW-1:0]     src_a;
      logic [CW-1:0]     src_b;
      logic [CW:0]       chunk;
      logic [DONE_W-1:0] sum_d;
      logic [DONE_W-1:0] sum_q;
      logic              vld_q;
      logic              cy_q;
      logic              sa_q;
      logic              sb_q;
      logic              load;

      if (k == 0) begin : g_head
         assign src_vld = in_valid;
         assign src_cin = cin_eff;
         assign src_sa  = in_a[WIDTH-1];
         assign src_sb  = b_eff[WIDTH-1];
         assign src_a   = in_a[CW-1:0];
         assign src_b   = b_eff[CW-1:0];
         assign sum_d   = chunk[CW-1:0];
      end else begin : g_body
         // The pending operand registers are kept shifted so that the chunk
         // for this stage always sits in the low CW bits.
         assign src_vld = g_stage[k-1].vld_q;
         assign src_cin = g_stage[k-1].cy_q;
         assign src_sa  = g_stage[k-1].sa_q;
         assign src_sb  = g_stage[k-1].sb_q;
         assign src_a   = g_stage[k-1].g_pend.pa_q[CW-1:0];
         assign src_b   = g_stage[k-1].g_pend.pb_q[CW-1:0];
         assign sum_d   = {chunk[CW-1:0], g_stage[k-1].sum_q};
      end

      assign chunk = {1'b0, src_a} + {1'b0, src_b} + {{CW{1'b0}}, src_cin};
      assign load  = adv[k] & src_vld;

      // ---- stage k register: valid, done sum bits, carry, operand signs ----
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q <= 1'b0;
            cy_q  <= 1'b0;
            sa_q  <= 1'b0;
            sb_q  <= 1'b0;
            sum_q <= '0;
         end else begin
            if (adv[k]) begin
               vld_q <= src_vld;
            end
            // Data only moves with a real beat, so a stalled or drained
            // stage keeps its last contents stable.
            if (load) begin
               cy_q  <= chunk[CW];
               sa_q  <= src_sa;
               sb_q  <= src_sb;
               sum_q <= sum_d;
            end
         end
      end

      if (PEND_W > 0) begin : g_pend
         logic [PEND_W-1:0] pa_d;
         logic [PEND_W-1:0] pb_d;
         logic [PEND_W-1:0] pa_q;
         logic [PEND_W-1:0] pb_q;

         if (k == 0) begin : g_from_in
            assign pa_d = in_a[WIDTH-1:CW];
            assign pb_d = b_eff[WIDTH-1:CW];
         end else begin : g_from_prev
            assign pa_d = g_stage[k-1].g_pend.pa_q[PEND_W+CW-1:CW];
            assign pb_d = g_stage[k-1].g_pend.pb_q[PEND_W+CW-1:CW];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pa_q <= '0;
               pb_q <= '0;
            end else if (load) begin
               pa_q <= pa_d;
               pb_q <= pb_d;
            end
         end
      end

      if (k == STAGES - 1) begin : g_tail
         // ---- last stage: zero flag registered alongside the final sum ----
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               zero_q <= 1'b0;
            end else if (load) begin
               zero_q <= (sum_d == '0);
            end
         end
      end

      assign vld_vec[k] = vld_q;
   end

   assign out_valid = g_stage[STAGES-1].vld_q;
   assign out_sum   = g_stage[STAGES-1].sum_q;
   assign out_carry = g_stage[STAGES-1].cy_q;
   assign out_zero  = zero_q;
   // Overflow: operands of equal sign produced a result of the other sign.
   // Derived purely from last-stage registers, so it resets to 0 with them.
   assign out_ovf   = (g_stage[STAGES-1].sa_q == g_stage[STAGES-1].sb_q) &&
                      (out_sum[WIDTH-1] != g_stage[STAGES-1].sa_q);

endmodule

// File: tb/tb_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_adder
//   Self-checking bench for pipe_adder. Main instance is 32 bits / 4 stages;
//   three further instances cover (8,1), (16,2) and (64,8).
// -----------------------------------------------------------------------------
module tb_pipe_adder;

   typedef struct packed {
      logic [31:0] sum;
      logic        c;
      logic        o;
      logic        z;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_sub, in_cin;
   logic        out_valid, out_ready, out_carry, out_ovf, out_zero;
   logic [31:0] in_a, in_b, out_sum;

   logic        sw_valid;
   logic [7:0]  ones8  = '1;
   logic [15:0] ones16 = '1;
   logic [63:0] ones64 = '1;
   logic        rdy8, rdy16, rdy64, v8, v16, v64;
   logic        c8, c16, c64, o8, o16, o64, z8, z16, z64;
   logic [7:0]  s8;
   logic [15:0] s16;
   logic [63:0] s64;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_adder #(.WIDTH(32), .STAGES(4)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero));

   pipe_adder #(.WIDTH(8), .STAGES(1)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy8),
      .in_a(ones8), .in_b(ones8), .in_sub(1'b0), .in_cin(1'b1),
      .out_valid(v8), .out_ready(1'b1), .out_sum(s8),
      .out_carry(c8), .out_ovf(o8), .out_zero(z8));

   pipe_adder #(.WIDTH(16), .STAGES(2)) u_w16 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy16),
      .in_a(ones16), .in_b(ones16), .in_sub(1'b0), .in_cin(1'b1),
      .out_valid(v16), .out_ready(1'b1), .out_sum(s16),
      .out_carry(c16), .out_ovf(o16), .out_zero(z16));

   pipe_adder #(.WIDTH(64), .STAGES(8)) u_w64 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy64),
      .in_a(ones64), .in_b(ones64), .in_sub(1'b0), .in_cin(1'b1),
      .out_valid(v64), .out_ready(1'b1), .out_sum(s64),
      .out_carry(c64), .out_ovf(o64), .out_zero(z64));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: true unsigned and signed results in 64-bit arithmetic.
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic sub, input logic cin);
      res_t   r;
      longint ua, ub, sa, sb, ci, ru, rs, lim;
      ua  = longint'(a);
      ub  = longint'(b);
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ci  = longint'(cin);
      lim = 64'sd2147483648;
      if (sub) begin
         ru  = ua - ub;
         rs  = sa - sb;
         r.c = (ua >= ub);
      end else begin
         ru  = ua + ub + ci;
         rs  = sa + sb + ci;
         r.c = (ru >= 64'sd4294967296);
      end
      r.sum = ru[31:0];
      r.o   = (rs >= lim) || (rs < -lim);
      r.z   = (r.sum == 32'h0);
      return r;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // One beat through the 32/4 instance with out_ready held high.
   task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic cin, input logic [31:0] es,
                           input logic ec, input logic eo, input logic ez);
      int n;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_sub    = sub;
      in_cin    = cin;
      #1;
      chk({tag, " in_ready"}, in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 12) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " latency"}, n, 4);
      chk({tag, " sum"},     out_sum,   es);
      chk({tag, " carry"},   out_carry, ec);
      chk({tag, " ovf"},     out_ovf,   eo);
      chk({tag, " zero"},    out_zero,  ez);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      res_t        exp_q[$];
      res_t        cur, prev_pk;
      logic        held;
      int          sent, rcvd, inflight, stale;
      int          lat8, lat16, lat64;
      logic [7:0]  g8;
      logic [15:0] g16;
      logic [63:0] g64;
      logic [2:0]  f8, f16, f64;

      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
      out_ready = 1'b0; sw_valid = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state while rst is high.
      chk("rst out_valid", out_valid, 1'b0);
      chk("rst out_sum",   out_sum,   32'h0);
      chk("rst carry",     out_carry, 1'b0);
      chk("rst ovf",       out_ovf,   1'b0);
      chk("rst zero",      out_zero,  1'b0);
      chk("rst in_ready",  in_ready,  1'b1);
      rst = 1'b0;
      @(negedge clk);
      chk("post-rst in_ready",  in_ready,  1'b1);
      chk("post-rst out_valid", out_valid, 1'b0);

      // Directed beats.
      directed("add 5+3",   32'h5,         32'h3, 1'b0, 1'b0, 32'h8,         1'b0, 1'b0, 1'b0);
      directed("add wrap",  32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1);
      directed("add ovf",   32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      directed("sub 5-7",   32'h5,         32'h7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      directed("sub 7-7",   32'h7,         32'h7, 1'b1, 1'b1, 32'h0,         1'b1, 1'b0, 1'b1);
      directed("sub ovf",   32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
      directed("add cin",   32'h0000_FFFF, 32'h0, 1'b0, 1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0);

      // Parameter sweep: all-ones + all-ones + 1 gives all-ones with carry.
      @(negedge clk);
      sw_valid = 1'b1;
      #1;
      chk("w8 in_ready",  rdy8,  1'b1);
      chk("w16 in_ready", rdy16, 1'b1);
      chk("w64 in_ready", rdy64, 1'b1);
      lat8 = 0; lat16 = 0; lat64 = 0;
      g8 = '0; g16 = '0; g64 = '0; f8 = '0; f16 = '0; f64 = '0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         sw_valid = 1'b0;
         if (v8 && lat8 == 0) begin
            lat8 = n; g8 = s8; f8 = {c8, o8, z8};
         end
         if (v16 && lat16 == 0) begin
            lat16 = n; g16 = s16; f16 = {c16, o16, z16};
         end
         if (v64 && lat64 == 0) begin
            lat64 = n; g64 = s64; f64 = {c64, o64, z64};
         end
      end
      chk("w8 latency",  lat8,  1);
      chk("w8 sum",      g8,    8'hFF);
      chk("w8 flags",    f8,    3'b100);
      chk("w16 latency", lat16, 2);
      chk("w16 sum",     g16,   16'hFFFF);
      chk("w16 flags",   f16,   3'b100);
      chk("w64 latency", lat64, 8);
      chk("w64 sum",     g64,   64'hFFFF_FFFF_FFFF_FFFF);
      chk("w64 flags",   f64,   3'b100);

      // Random traffic with output stalls against the reference model.
      sent = 0; rcvd = 0; inflight = 0; held = 1'b0; prev_pk = '0;
      for (int cyc = 0; cyc < 3000 && (sent < 100 || rcvd < 100); cyc++) begin
         @(negedge clk);
         cur = {out_sum, out_carry, out_ovf, out_zero};
         if (held) chk("stall hold", {out_valid, cur}, {1'b1, prev_pk});
         if (out_valid) begin
            if (exp_q.size() == 0) chk("spurious beat", 1'b1, 1'b0);
            else chk($sformatf("beat %0d", rcvd), cur, exp_q[0]);
         end
         out_ready = ((cyc % 40) < 8) ? 1'b0 : 1'($urandom_range(0, 1));
         in_valid  = (sent < 100) && ($urandom_range(0, 9) != 0);
         in_a      = pick();
         in_b      = pick();
         in_sub    = 1'($urandom_range(0, 1));
         in_cin    = 1'($urandom_range(0, 1));
         #1;
         chk("in_ready", in_ready, !(inflight == 4 && !out_ready));
         if (out_valid && out_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            rcvd++;
            inflight--;
         end
         held    = out_valid && !out_ready;
         prev_pk = cur;
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_a, in_b, in_sub, in_cin));
            sent++;
            inflight++;
         end
      end
      chk("random beats out", rcvd, 100);
      chk("random queue empty", exp_q.size(), 0);

      // Reset with three beats in flight.
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1; in_sub = 1'b0; in_cin = 1'b0;
      in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF;
      @(negedge clk);
      in_a = 32'h1; in_b = 32'h2;
      @(negedge clk);
      in_a = 32'h3; in_b = 32'h4;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("pre-rst out_valid", out_valid, 1'b1);
      chk("pre-rst sum",       out_sum,   32'hFFFF_FFFE);
      rst = 1'b1;
      #1;
      chk("mid-rst out_valid", out_valid, 1'b0);
      chk("mid-rst out_sum",   out_sum,   32'h0);
      chk("mid-rst flags",     {out_carry, out_ovf, out_zero}, 3'b000);
      chk("mid-rst in_ready",  in_ready,  1'b1);
      @(negedge clk);
      rst = 1'b0;
      stale = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      chk("stale beats after reset", stale, 0);
      directed("after rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined integer adder/subtractor with a valid/ready handshake. It generalises the team's 32-bit ripple-carry adder: WIDTH and pipeline depth are configurable, subtraction and carry-in are supported, and carry/overflow/zero flags are produced. The carry chain is split into STAGES equal chunks, one chunk per pipeline stage, so a long chain closes timing at one result per cycle. The block sits between operand issue and writeback in the execute path.

## Interface
- WIDTH, default 32: operand/result width in bits.
- STAGES, default 4: number of pipeline stages (chunks); WIDTH % STAGES must be 0, STAGES ≥ 1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sub  input  1  0: A+B+cin; 1: A+~B+1 (cin ignored).
- in_cin  input  1  carry-in for add.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result this cycle.
- out_sum  output  WIDTH  result, modulo 2^WIDTH.
- out_carry  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow).
- out_ovf  output  1  signed overflow.
- out_zero  output  1  out_sum == 0.

## Operation
- CW = WIDTH/STAGES. Effective B = in_sub ? ~in_b : in_b; effective cin = in_sub ? 1 : in_cin.
- Stage k (0..STAGES-1) computes bits [k*CW +: CW] with a ripple chain using the carry registered from stage k-1 (stage 0 uses effective cin); its register holds: valid bit, finished low sum chunks, still-pending high A/B chunks, carry, and the sign bits of A and effective B.
- Last stage register drives the outputs directly (registered outputs, no combinational path input→output).
- out_ovf = (signA == signBeff) && (sum[WIDTH-1] != signA).
- out_zero computed on the final sum inside the last stage.
- Flow control per stage: stage k loads when its register is empty or downstream is taking its contents (advance_k = !v_k || advance_{k+1}, with advance_STAGES = out_ready). Bubbles collapse; stalls do not lose or duplicate beats.
- in_ready = advance_0 (depends on out_ready combinationally only through the valid chain; no path from in_valid).
- Beats leave in issue order; one transfer per cycle on each side when both valid and ready.
- STAGES = 1: single registered adder, latency 1.

## Timing
- Reset (async assert, sync to clk edge irrelevant): all stage valid bits 0; out_valid=0, out_sum=0, out_carry=0, out_ovf=0, out_zero=0; in_ready=1 one cycle after... none: in_ready=1 while rst is high and after release (pipeline empty).
- Reset mid-operation: every in-flight beat is discarded; nothing emerges after release until new input.
- Latency: beat accepted at edge t appears with out_valid=1 after edge t+STAGES-1, i.e. visible in cycle t+STAGES, when out_ready held high.
- Throughput: 1 beat/cycle with out_ready=1.
- out_valid && !out_ready: out_* hold stable until accepted; upstream stages fill, then in_ready drops after STAGES stalled beats are resident.
- Simultaneous accept at output and input on a full pipeline: both transfers occur same cycle; in_ready stays 1.
- Wrap-around: sums wrap modulo 2^WIDTH; carry reported in out_carry.

## Test plan
- WIDTH=32, STAGES=4, out_ready=1: A=0x0000_0005, B=0x0000_0003, add, cin=0 → 4 cycles later sum=0x8, carry=0, ovf=0, zero=0.
- Cross-chunk carry: A=0xFFFF_FFFF, B=0x1, add → sum=0x0, carry=1, ovf=0, zero=1; A=0x7FFF_FFFF, B=0x1 → sum=0x8000_0000, ovf=1, carry=0.
- Sub: A=5, B=7 → sum=0xFFFF_FFFE, carry=0 (borrow); A=7, B=7 → sum=0, carry=1, zero=1; A=0x8000_0000, B=1 → sum=0x7FFF_FFFF, ovf=1.
- Back-to-back 100 random beats with random out_ready toggling → every beat emerges once, in order, matching a reference model; out_* stable while stalled; in_ready low exactly when all 4 stages hold beats and out_ready=0.
- Reset asserted with 3 beats in flight → out_valid=0 immediately, all outputs 0; after release no stale beat appears; next beat returns after 4 cycles.
- Parameter sweep: (WIDTH,STAGES) = (8,1), (16,2), (64,8) with carry-in=1 and all-ones operands → sum = all-ones, carry=1; latency equals STAGES.
